wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 4, meaning the register write-data width.
REQ-002 The module SHALL have parameter ADDR_W, default 2, meaning the register-select width.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port stall  input  1  blocks all grants while high.
REQ-007 Port req0_valid  input  1  requester 0 (ALU path) has a write pending.
REQ-008 Port req0_addr  input  ADDR_W  requester 0 destination register.
REQ-009 Port req0_data  input  DATA_W  requester 0 write data.
REQ-010 Port req0_ready  output  1  requester 0 accepted this cycle.
REQ-011 Ports req1_valid, req1_addr, req1_data, req1_ready SHALL mirror REQ-007..010 for requester 1 (Write/load path).
REQ-012 Port wr_en  output  1  register-file write enable.
REQ-013 Port wr_addr  output  ADDR_W  register-file write address.
REQ-014 Port wr_data  output  DATA_W  register-file write data.
REQ-015 Port conflict_cnt  output  8  saturating count of cycles both requesters were valid.

Function
REQ-016 A transfer on requester i SHALL occur when reqi_valid and reqi_ready are both high in the same cycle.
REQ-017 reqi_ready SHALL be combinational: high only when stall=0, reqi_valid=1, and requester i holds the grant per REQ-018.
REQ-018 The grant SHALL be given to the sole valid requester; when both are valid, to the requester named by the priority state.
REQ-019 The priority FSM SHALL have two states, PRI0 and PRI1; reset state PRI0.
REQ-020 After a transfer from requester 0 the FSM SHALL go to PRI1; after a transfer from requester 1, to PRI0; with no transfer it SHALL hold.
REQ-021 At most one requester SHALL be ready in any cycle.
REQ-022 On a transfer, wr_en SHALL go high on the next rising edge, with wr_addr/wr_data equal to the transferring requester's addr/data (latency exactly 1 cycle).
REQ-023 In a cycle with no transfer, wr_en SHALL be 0 on the next edge, and wr_addr SHALL hold its last value.
REQ-024 wr_data SHALL read as all-zero whenever wr_en=0 (data gated by enable).
REQ-025 Back-to-back transfers SHALL produce wr_en high on consecutive cycles with no bubble.
REQ-026 Both requesters valid with the same address SHALL be arbitrated as normal; no merging or dropping; both writes SHALL appear in grant order.
REQ-027 stall=1 SHALL deassert both readys, freeze the FSM, and yield wr_en=0 on the next edge; a write already registered SHALL still be presented for its one cycle.
REQ-028 conflict_cnt SHALL increment by 1 on every edge where req0_valid=req1_valid=1 (regardless of stall) and SHALL saturate at 255.
REQ-029 A requester that deasserts valid before being granted SHALL lose no state in the arbiter; nothing is buffered on its behalf.

Reset
REQ-030 While rst=1, the FSM SHALL be PRI0, wr_en=0, wr_addr=0, wr_data=0, conflict_cnt=0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard the registered write (wr_en=0 immediately); no write SHALL be issued for a transfer in the cycle reset is released.
REQ-032 While rst=1, req0_ready and req1_ready SHALL be 0.

Verification
REQ-033 Reset, then req0 valid addr=2 data=9 alone -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=2, wr_data=9; following cycle wr_en=0, wr_data=0.
REQ-034 Both valid every cycle (req0 addr=1 data=3, req1 addr=1 data=5) for 4 cycles -> grants 0,1,0,1; wr_data sequence 3,5,3,5 on consecutive cycles; conflict_cnt=4.
REQ-035 Both valid with stall=1 for 3 cycles, then stall=0 -> no ready and wr_en=0 during stall, FSM unchanged, conflict_cnt=3; first grant after stall goes to the pre-stall priority.
REQ-036 Hold both valid for 300 cycles -> conflict_cnt stops at 255.
REQ-037 Assert rst one cycle after a transfer of data=7 -> wr_en drops to 0 asynchronously, conflict_cnt=0, FSM back to PRI0; first post-reset conflict granted to requester 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-requester register-file write arbiter: alternating priority on contention,
// one-cycle registered write port and a saturating count of contended cycles.
module wb_arbiter #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        conflict_cnt
);

    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_e;

    pri_e              state_q, state_d;
    // High for the first cycle after reset release so no transfer can be taken then.
    logic              boot_q;
    logic              grant0_s, grant1_s;
    logic              xfer0_s, xfer1_s;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [7:0]        cnt_q, cnt_d;

    // Grant selection, ready generation and priority next state
    always_comb begin
        grant0_s   = 1'b0;
        grant1_s   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_d    = state_q;
        case ({req1_valid, req0_valid})
            2'b01: grant0_s = 1'b1;
            2'b10: grant1_s = 1'b1;
            2'b11: begin
                if (state_q == PRI0) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
        if (rst || boot_q || stall) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end else begin
            req0_ready = grant0_s;
            req1_ready = grant1_s;
        end
        xfer0_s = req0_valid & req0_ready;
        xfer1_s = req1_valid & req1_ready;
        if (xfer0_s) begin
            state_d = PRI1;
        end else if (xfer1_s) begin
            state_d = PRI0;
        end else begin
            state_d = state_q;
        end
    end

    // Write-port next state and saturating conflict counter
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = {DATA_W{1'b0}};
        cnt_d     = cnt_q;
        if (xfer0_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = req0_addr;
            wr_data_d = req0_data;
        end else if (xfer1_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = req1_addr;
            wr_data_d = req1_data;
        end else begin
            wr_en_d   = 1'b0;
            wr_addr_d = wr_addr_q;
            wr_data_d = {DATA_W{1'b0}};
        end
        if (req0_valid && req1_valid && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PRI0;
            boot_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            boot_q    <= 1'b0;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign conflict_cnt = cnt_q;

endmodule
